// File: rtl/sum_uart_pkg.sv
// Shared types and line-level constants for the adder-sum UART transmitter.
package sum_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS  = 8;

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Wrap at the end of each bit; restart aligns the count to a new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/sum_uart_tx.sv
// One-byte buffered 8N1 UART transmitter (optional even parity) for the adder sum.
// The chip top feeds data_in = ui_in + uio_in and routes tx to a uo_out pin.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy
);

    uart_state_t          state, state_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic                 par_bit, par_nxt;
    logic [DATA_BITS-1:0] buf_data;
    logic                 buf_full;
    logic                 tx_q, tx_nxt;
    logic                 load;
    logic                 accept;
    logic                 tick;
    logic                 restart;

    // ready_out is the inverted buffer flag, so valid_in never reaches it.
    assign ready_out = !buf_full;
    assign accept    = valid_in && !buf_full;
    assign busy      = (state != IDLE) || buf_full;
    assign tx        = tx_q;

    // Hold the counter at zero while idle and re-zero it on every state change.
    assign restart = (state_nxt != state) || (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    // Next-state, shifter and line-level decode; tx is looked ahead so it can be registered.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        par_nxt     = par_bit;
        load        = 1'b0;
        tx_nxt      = IDLE_LEVEL;

        case (state)
            IDLE: begin
                if (buf_full) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt   = shift >> 1;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1))
                        state_nxt = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick)
                    state_nxt = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (buf_full) begin
                        // Back-to-back: straight into the next start bit.
                        load      = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            shift_nxt   = buf_data;
            par_nxt     = even_parity(buf_data);
            bit_idx_nxt = 3'd0;
        end

        case (state_nxt)
            START:   tx_nxt = START_BIT;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_nxt;
            STOP:    tx_nxt = STOP_BIT;
            default: tx_nxt = IDLE_LEVEL;
        endcase
    end

    // FSM, shifter and glitch-free line register; reset drops any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= 3'd0;
            par_bit <= 1'b0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            par_bit <= par_nxt;
            tx_q    <= tx_nxt;
        end
    end

    // Single holding slot: filled on handshake, emptied when the shifter takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (load) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= data_in;
        end
    end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: two instances (no parity / even parity) at 4 clocks per bit,
// a frame-level line model, a simple UART receiver on the no-parity line, and literal checks.
module tb_sum_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din   [2];
    logic       vin   [2];
    logic       ready [2];
    logic       txo   [2];
    logic       busy  [2];

    sum_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .valid_in(vin[0]),
        .ready_out(ready[0]), .tx(txo[0]), .busy(busy[0]));

    sum_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .valid_in(vin[1]),
        .ready_out(ready[1]), .tx(txo[1]), .busy(busy[1]));

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- line model ----------------
    // Each instance: a one-slot buffer plus the current frame as a bit vector
    // (bit 0 = start) and a cycle position inside it.
    logic        m_full [2] = '{1'b0, 1'b0};
    logic [7:0]  m_buf  [2];
    logic [10:0] m_bits [2];
    int          m_pos  [2] = '{0, 0};
    int          m_len  [2] = '{0, 0};
    int          acc_cnt[2] = '{0, 0};
    int          acc_cyc[2] = '{0, 0};
    int          cyc = 0;

    always @(posedge clk or posedge rst) begin
        logic old;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_full[d] = 1'b0;
                m_len[d]  = 0;
                m_pos[d]  = 0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                old = m_full[d];
                if (m_len[d] != 0) begin
                    m_pos[d]++;
                    if (m_pos[d] == m_len[d]) m_len[d] = 0;
                end
                if (m_len[d] == 0 && old) begin
                    if (d == 1) begin
                        m_bits[d] = {1'b1, ^m_buf[d], m_buf[d], 1'b0};
                        m_len[d]  = 11 * CPB;
                    end else begin
                        m_bits[d] = {2'b11, m_buf[d], 1'b0};
                        m_len[d]  = 10 * CPB;
                    end
                    m_pos[d]  = 0;
                    m_full[d] = 1'b0;
                end
                if (vin[d] && !old) begin
                    m_full[d] = 1'b1;
                    m_buf[d]  = din[d];
                    acc_cnt[d]++;
                    acc_cyc[d] = cyc;
                end
            end
        end
    end

    function automatic logic exp_tx(input int d);
        return (m_len[d] != 0) ? m_bits[d][m_pos[d] / CPB] : 1'b1;
    endfunction

    // Every cycle, every output of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("tx%0d", d), txo[d], exp_tx(d));
            chk($sformatf("ready%0d", d), ready[d], !m_full[d]);
            chk($sformatf("busy%0d", d), busy[d], (m_len[d] != 0) || m_full[d]);
        end
    end

    // ---------------- receiver on the no-parity line ----------------
    int         rxq[$];
    logic       rx_act = 1'b0;
    int         rx_ph = 0;
    logic [7:0] rx_sh = '0;

    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (txo[0] == 1'b0) begin
                rx_act = 1'b1;
                rx_ph  = 1;
                rx_sh  = '0;
            end
        end else begin
            if (rx_ph >= 6 && rx_ph <= 34 && (rx_ph % 4) == 2)
                rx_sh = {txo[0], rx_sh[7:1]};
            if (rx_ph == 38) begin
                rxq.push_back(txo[0] ? int'(rx_sh) : -1);
                rx_act = 1'b0;
            end
            rx_ph++;
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    logic captx [80];
    logic capb  [80];

    task automatic send(input int d, input logic [7:0] v, input bit keep);
        int c0;
        c0 = acc_cnt[d];
        vin[d] = 1'b1;
        din[d] = v;
        for (int i = 0; i < 300 && acc_cnt[d] == c0; i++) @(negedge clk);
        chk("accept_timeout", acc_cnt[d] != c0, 1);
        if (!keep) vin[d] = 1'b0;
    endtask

    task automatic cap(input int d, input int n);
        for (int c = 0; c < n; c++) begin
            captx[c] = txo[d];
            capb[c]  = busy[d];
            @(negedge clk);
        end
    endtask

    function automatic int busy_count(input int n);
        int b = 0;
        for (int c = 0; c < n; c++) if (capb[c]) b++;
        return b;
    endfunction

    task automatic wait_idle(input int d);
        for (int i = 0; i < 300 && (m_len[d] != 0 || m_full[d]); i++) @(negedge clk);
        chk("idle_timeout", (m_len[d] == 0) && !m_full[d], 1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int hi, n0, a1;
        int s_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        vin[0] = 1'b0; vin[1] = 1'b0;
        din[0] = '0;   din[1] = '0;

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx0", txo[0], 1);
        chk("rst_ready0", ready[0], 1);
        chk("rst_busy0", busy[0], 0);
        chk("rst_tx1", txo[1], 1);
        chk("rst_ready1", ready[1], 1);
        chk("rst_busy1", busy[1], 0);
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (txo[0] === 1'b1 && txo[1] === 1'b1) hi++;
        end
        chk("idle_high_cycles", hi, 50);

        // Single byte 0xA5, no parity
        send(0, 8'hA5, 1'b0);
        cap(0, 60);
        chk("a5_latency", captx[0], 1);
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++)
                chk($sformatf("a5_bit%0d", k), captx[1 + CPB * k + j], s_a5[k]);
        chk("a5_busy_cycles", busy_count(60), 41);
        chk("a5_end_tx", captx[41], 1);
        chk("a5_end_busy", capb[41], 0);
        wait_idle(0);

        // Back-to-back 0x00 then 0xFF
        send(0, 8'h00, 1'b1);
        chk("b2b_ready_low", ready[0], 0);
        a1 = acc_cyc[0];
        send(0, 8'hFF, 1'b0);
        chk("b2b_accept_gap", acc_cyc[0] - a1, 2);
        cap(0, 50);
        chk("b2b_last_data", captx[34], 0);
        chk("b2b_stop", captx[38], 1);
        chk("b2b_next_start", captx[39], 0);
        chk("b2b_ff_bit0", captx[43], 1);
        wait_idle(0);

        // Even parity: 0x07 -> 1, 0x03 -> 0
        send(1, 8'h07, 1'b0);
        cap(1, 60);
        chk("p07_start", captx[1], 0);
        chk("p07_d0", captx[5], 1);
        chk("p07_d3", captx[17], 0);
        chk("p07_parity", captx[37], 1);
        chk("p07_stop", captx[44], 1);
        chk("p07_busy_cycles", busy_count(60), 45);
        chk("p07_end_busy", capb[45], 0);
        wait_idle(1);
        send(1, 8'h03, 1'b0);
        cap(1, 60);
        chk("p03_parity", captx[37], 0);
        chk("p03_busy_cycles", busy_count(60), 45);
        wait_idle(1);

        // Reset during data bit 3 of 0x5A with 0x99 waiting in the buffer
        n0 = rxq.size();
        send(0, 8'h5A, 1'b0);
        send(0, 8'h99, 1'b0);
        repeat (16) @(negedge clk);
        chk("mid_busy_before", busy[0], 1);
        chk("mid_ready_before", ready[0], 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", txo[0], 1);
        chk("mid_rst_ready", ready[0], 1);
        chk("mid_rst_busy", busy[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(0, 8'hC3, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("mid_rx_count", rxq.size() - n0, 1);
        chk("mid_rx_byte", rxq[rxq.size() - 1], 32'hC3);

        // Buffer stall with valid held across three bytes
        n0 = rxq.size();
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        send(0, 8'h33, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("stall_rx_count", rxq.size() - n0, 3);
        if (rxq.size() - n0 == 3) begin
            chk("stall_byte0", rxq[n0], 32'h11);
            chk("stall_byte1", rxq[n0 + 1], 32'h22);
            chk("stall_byte2", rxq[n0 + 2], 32'h33);
        end

        // Random valid/data traffic on both instances
        repeat (2500) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                vin[d] = ($urandom_range(0, 2) == 0);
                din[d] = 8'($urandom);
            end
        end
        @(negedge clk);
        vin[0] = 1'b0;
        vin[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sum_uart_tx.md
# sum_uart_tx

Serial output stage placed directly downstream of the `tt_um_bleeptrack_nn2` adder. It accepts the 8-bit sum through a valid/ready handshake and buffers one byte. It transmits each byte as an 8N1 UART frame on a single `uo_out` pin, with optional even parity. This lets the result be read off-chip over one wire instead of eight.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit. Must be ≥ 2; the default gives 115200 baud at 50 MHz.
- `PARITY_EN`, default 0: 0 = no parity (10-bit frame); 1 = even parity bit after the data bits (11-bit frame).

Ports:
- `clk` in, 1 bit: the single clock.
- `rst` in, 1 bit: reset, **asynchronous, active-high**.
- `data_in` in, 8 bits: byte to send (the adder sum).
- `valid_in` in, 1 bit: `data_in` is valid.
- `ready_out` out, 1 bit: holding buffer is empty and can accept a byte.
- `tx` out, 1 bit: UART line, idle high.
- `busy` out, 1 bit: a frame is in progress, or a byte is waiting in the buffer.

## Operation
- Handshake:
  - A byte is accepted on a rising edge where `valid_in && ready_out`.
  - `ready_out = !buf_full`. It is a registered flag, with no combinational path from `valid_in`.
- Holding buffer: one entry.
  - It is written on accept.
  - It is cleared when the shifter loads from it.
  - It is never overwritten while full.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx=1`. If `buf_full`, load the shifter, clear the buffer and go to START.
  - START: `tx=0` for one bit period, then go to DATA with `bit_idx=0`.
  - DATA: `tx=shift[0]`, sent LSB first. At the end of each bit period, shift right and increment `bit_idx`. After bit 7, go to PARITY if `PARITY_EN`, otherwise go to STOP.
  - PARITY: `tx` = XOR of the 8 data bits (even parity), for one bit period, then go to STOP.
  - STOP: `tx=1` for one bit period. At the end, if `buf_full`, load the shifter and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT-1`.
  - Resets to 0 on every state entry.
  - The end-of-bit tick fires when the count equals `CLKS_PER_BIT-1`.
  - Counter width is `$clog2(CLKS_PER_BIT)`.
- `busy = (state != IDLE) || buf_full`.
- Simultaneous events: an accept cannot coincide with a shifter load from the buffer, because `ready_out` is 0 while the buffer is full. The buffer refills one cycle after the load at the earliest.

## Timing
- Reset values: `tx=1`, `ready_out=1`, `busy=0`, state IDLE, buffer empty, counter 0, `bit_idx` 0.
- Reset is asynchronous. Asserting `rst` mid-frame forces `tx=1` immediately and discards both the shifter and the buffer contents. The upstream stage must not present `valid_in` while `rst` is high.
- Latency: for an accept at edge N with the FSM idle, `tx` falls at edge N+1.
- Each bit holds for exactly `CLKS_PER_BIT` cycles.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11× when parity is enabled.
- `ready_out`:
  - Falls at the accept edge.
  - Rises at the edge where the shifter loads from the buffer.
- Back-to-back throughput: when the buffer is full at the stop-bit tick, the next start bit begins on the very next cycle.

## Structure
- Shared package `sum_uart_pkg` holds:
  - the state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `START_BIT=1'b0`, `STOP_BIT=1'b1`, `IDLE_LEVEL=1'b1`, `DATA_BITS=8`.
- Sub-module `uart_baud_gen`:
  - parameter `CLKS_PER_BIT`;
  - inputs `clk`, `rst`, `restart`;
  - output `tick`.
- The top level instantiates `sum_uart_tx` with `data_in = ui_in + uio_in`, and `tx` drives one `uo_out` bit.

## Test plan
All scenarios use `CLKS_PER_BIT=4`.
- Reset: assert `rst` for 3 cycles, then release -> `tx=1`, `ready_out=1`, `busy=0`, and `tx` stays high for 50 idle cycles.
- Single byte 0xA5, `PARITY_EN=0`, accepted at edge N -> `tx` falls at N+1. Bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `busy` stays high for 41 cycles, then `tx=1` with `busy=0`.
- Back-to-back: send 0x00, then hold `valid_in` with 0xFF -> `ready_out=0` until the first frame's shifter load. 0xFF is accepted one cycle later. Its start bit immediately follows the 0x00 stop bit, with no idle cycle.
- Parity: `PARITY_EN=1`, byte 0x07 -> parity bit = 1 and an 11-bit frame (44 cycles). Byte 0x03 -> parity bit = 0.
- Reset mid-frame: assert `rst` during data bit 3 of 0x5A -> `tx=1` within the same cycle and `ready_out=1`. After release, sending 0xC3 produces a correct frame with no residue of 0x5A.
- Buffer stall: hold `valid_in` across the bytes 0x11, 0x22, 0x33 -> all three are emitted in order. None is duplicated or dropped, and `data_in` is sampled only on handshake edges.
